cp0_exception: RTL and testbench
================================

# cp0_exception

Coprocessor-0 and exception-commit unit placed beside the memory stage of the 5-stage MIPS pipeline. Each cycle it consumes the 8-bit exception vector, PC, delay-slot flag and faulting data address carried out of the memory stage. It resolves the highest-priority exception or interrupt and drives a pipeline flush plus redirect PC. It owns the architectural CP0 registers for `mfc0`/`mtc0`: BadVAddr, Count, Compare, Status, Cause, EPC and PRId, plus the Count/Compare timer interrupt.

## Interface
- `EXC_VECTOR`, 32'hBFC0_0380, redirect PC for every exception and interrupt.
- `PRID_VALUE`, 32'h0000_4220, read-only PRId contents.

- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `we_i` in 1: `mtc0` write enable, from write-back.
- `waddr_i` in 5: `mtc0` register number.
- `wdata_i` in 32: `mtc0` data.
- `raddr_i` in 5: `mfc0` register number, from decode.
- `rdata_o` out 32: `mfc0` read data.
- `int_i` in 6: hardware interrupt lines, level-sensitive.
- `except_i` in 8: exception vector from memory stage:
  - [7] fetch AdEL
  - [6] syscall
  - [5] break
  - [4] eret
  - [3] reserved instruction
  - [2] overflow
  - [1] data AdEL
  - [0] AdES
- `pc_i` in 32: memory-stage PC.
- `is_slot_i` in 1: memory-stage instruction is in a delay slot.
- `bad_addr_i` in 32: memory-stage data address (ALU result).
- `flush_o` out 1: flush all stages F–M this cycle.
- `new_pc_o` out 32: redirect target, valid when `flush_o` is high.
- `status_o` out 32: current Status register.
- `cause_o` out 32: current Cause register.
- `epc_o` out 32: current EPC register.

## Operation
- **Register map:** 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId. Any other address reads 0 and ignores writes.
- **Writable bits:**
  - Status: IM[15:8], EXL[1], IE[0]. Status[22] (BEV) is constant 1; all other Status bits read 0.
  - Cause: only IP[9:8] (software interrupts).
  - BadVAddr and PRId: writes ignored.
- **Cause.IP updates:** IP[15:10] is loaded every cycle from `int_i`. IP[15] is additionally ORed with the timer-interrupt flag.
- **Interrupt pending:** `|(Cause.IP & Status.IM) & Status.IE & ~Status.EXL`. A pending interrupt is taken only when `pc_i != 0`, so no interrupt is taken on a bubble.
- **Priority, highest first:** interrupt (0x00), fetch AdEL (0x04), RI (0x0a), syscall (0x08), break (0x09), overflow (0x0c), data AdEL (0x04), AdES (0x05), eret. The value in parentheses is the Cause.ExcCode written.
- **On a taken exception or interrupt:**
  - If EXL was 0: EPC ← `is_slot_i ? pc_i-4 : pc_i` and Cause.BD ← `is_slot_i`. If EXL was 1, EPC and BD are unchanged.
  - Status.EXL ← 1; Cause.ExcCode ← code.
  - BadVAddr ← `pc_i` for fetch AdEL, or `bad_addr_i` for data AdEL/AdES.
  - `flush_o`=1, `new_pc_o`=`EXC_VECTOR`.
- **On eret (no higher exception):** Status.EXL ← 0, `flush_o`=1, `new_pc_o`=EPC.
- **Count:** increments by 1 every second cycle via an internal toggle bit. It wraps 32'hFFFF_FFFF → 0.
- **Timer:** timer flag sets when Count==Compare. A write to Compare clears the flag.
- **Read:** `rdata_o` is combinational. It bypasses `wdata_i` when `we_i` is high and `waddr_i`==`raddr_i`.

## Timing
- `flush_o` and `new_pc_o` are combinational from inputs and current state, with zero latency. Register updates land at the next rising `clk`.
- **Reset values:**
  - Status=32'h0040_0000; all other registers, toggle and timer flag = 0.
  - `flush_o`=0, `new_pc_o`=0.
  - `status_o`=32'h0040_0000; `cause_o`=0, `epc_o`=0.
- **Exception and `mtc0` in the same cycle:** the exception wins and the write is dropped entirely.
- **Count write vs increment, same cycle:** the write wins and the toggle clears.
- **`mtc0` to Status clearing EXL, same cycle as an interrupt arrives:** the interrupt is evaluated against the pre-write Status.
- **Multiple `except_i` bits set:** only the highest-priority bit has any effect.
- **`rst` asserted mid-exception:** reset overrides all updates in that cycle.

## Structure
- **Package `cp0_pkg`:** CP0 register-number constants, ExcCode constants, `except_i` bit-index constants, Status/Cause field positions, Status reset value.
- **Sub-module `cp0_exc_prio`:** combinational priority encoder. Takes `except_i` and the interrupt-pending bit. Outputs take/eret flags and ExcCode.

## Test plan
- After reset, `mfc0` of 12 returns 32'h0040_0000. Write 32'h0000_FF03 to Status, then read 12 → 32'h0040_FF03.
- **Overflow in delay slot:** Status=0x0000_0001, EXL=0, `except_i`=8'h04, `pc_i`=32'hBFC0_1004, `is_slot_i`=1. Required: `flush_o`=1, `new_pc_o`=32'hBFC0_0380. Next cycle EPC=32'hBFC0_1000, Cause.BD=1, ExcCode=0x0c, EXL=1.
- **Data AdES:** `except_i`=8'h01, `bad_addr_i`=32'h8000_0002. Required: BadVAddr=32'h8000_0002, ExcCode=0x05.
- **Timer:** Status=32'h0000_8001, Compare=10. Required: Count reaches 10 after 20 cycles; the next valid `pc_i` takes an interrupt with ExcCode 0. A write to Compare deasserts Cause.IP[15].
- **eret:** with EPC=32'hBFC0_0100 and EXL=1, `except_i`=8'h10. Required: `flush_o`=1, `new_pc_o`=32'hBFC0_0100, EXL=0 next cycle.
- **Syscall with concurrent `mtc0`:** `except_i`=8'h60 (syscall+break) with `we_i`=1 to EPC in the same cycle. Required: ExcCode=0x08 and EPC gets `pc_i`, not `wdata_i`.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 / exception-commit unit: register numbers,
// ExcCodes, exception-vector bit positions and Status/Cause field layout.
package cp0_pkg;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] PRID_VALUE   = 32'h0000_4220;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int EX_FETCH_ADEL = 7;
  localparam int EX_SYSCALL    = 6;
  localparam int EX_BREAK      = 5;
  localparam int EX_ERET       = 4;
  localparam int EX_RI         = 3;
  localparam int EX_OVERFLOW   = 2;
  localparam int EX_DATA_ADEL  = 1;
  localparam int EX_ADES       = 0;

  localparam int ST_IE   = 0;
  localparam int ST_EXL  = 1;
  localparam int CS_BD   = 31;

  typedef enum logic [1:0] {
    BAD_NONE  = 2'd0,
    BAD_FETCH = 2'd1,
    BAD_DATA  = 2'd2
  } badSrcT;

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational priority resolver: picks the single winning exception or
// interrupt, its ExcCode and where BadVAddr should be loaded from.
module cp0_exc_prio
  import cp0_pkg::*;
(
  input  logic [7:0] exceptVec,
  input  logic       intPending,
  output logic       excTake,
  output logic       eretTake,
  output logic [4:0] excCode,
  output badSrcT     badSrc
);

  always_comb begin
    excTake  = 1'b1;
    eretTake = 1'b0;
    excCode  = EXC_INT;
    badSrc   = BAD_NONE;
    if (intPending) begin
      excCode = EXC_INT;
    end else if (exceptVec[EX_FETCH_ADEL]) begin
      excCode = EXC_ADEL;
      badSrc  = BAD_FETCH;
    end else if (exceptVec[EX_RI]) begin
      excCode = EXC_RI;
    end else if (exceptVec[EX_SYSCALL]) begin
      excCode = EXC_SYS;
    end else if (exceptVec[EX_BREAK]) begin
      excCode = EXC_BP;
    end else if (exceptVec[EX_OVERFLOW]) begin
      excCode = EXC_OV;
    end else if (exceptVec[EX_DATA_ADEL]) begin
      excCode = EXC_ADEL;
      badSrc  = BAD_DATA;
    end else if (exceptVec[EX_ADES]) begin
      excCode = EXC_ADES;
      badSrc  = BAD_DATA;
    end else begin
      // eret only redirects when nothing above it fired
      excTake  = 1'b0;
      eretTake = exceptVec[EX_ERET];
    end
  end

endmodule

// File: rtl/cp0_exception.sv
// CP0 register file plus exception commit: resolves the memory-stage
// exception/interrupt, flushes and redirects, and runs the Count/Compare timer.
module cp0_exception
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [5:0]  int_i,
  input  logic [7:0]  except_i,
  input  logic [31:0] pc_i,
  input  logic        is_slot_i,
  input  logic [31:0] bad_addr_i,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [7:0]  statusIm;
  logic        statusExl, statusIe;
  logic        causeBd;
  logic [5:0]  causeIpHw;
  logic [1:0]  causeIpSw;
  logic [4:0]  causeCode;
  logic [31:0] epc, badVAddr, count, compare;
  logic        countTog, timerFlag;

  logic [7:0]  causeIp;
  logic [31:0] statusVal, causeVal;
  logic        intPending, excTake, eretTake, wrEn;
  logic [4:0]  excCode;
  badSrcT      badSrc;

  assign causeIp = {causeIpHw[5] | timerFlag, causeIpHw[4:0], causeIpSw};

  always_comb begin
    statusVal         = STATUS_RESET;
    statusVal[15:8]   = statusIm;
    statusVal[ST_EXL] = statusExl;
    statusVal[ST_IE]  = statusIe;
  end

  assign causeVal = {causeBd, 15'b0, causeIp, 1'b0, causeCode, 2'b0};

  // Evaluated against registered Status, so a same-cycle mtc0 cannot mask it
  assign intPending = (|(causeIp & statusIm)) & statusIe & ~statusExl & (pc_i != 32'd0);

  cp0_exc_prio u_prio (
    .exceptVec (except_i),
    .intPending(intPending),
    .excTake   (excTake),
    .eretTake  (eretTake),
    .excCode   (excCode),
    .badSrc    (badSrc)
  );

  assign wrEn = we_i & ~excTake;

  always_ff @(posedge clk) begin
    if (rst) begin
      statusIm  <= 8'd0;
      statusExl <= 1'b0;
      statusIe  <= 1'b0;
      causeBd   <= 1'b0;
      causeIpHw <= 6'd0;
      causeIpSw <= 2'd0;
      causeCode <= 5'd0;
      epc       <= 32'd0;
      badVAddr  <= 32'd0;
      count     <= 32'd0;
      compare   <= 32'd0;
      countTog  <= 1'b0;
      timerFlag <= 1'b0;
    end else begin
      causeIpHw <= int_i;
      countTog  <= ~countTog;
      if (countTog) count <= count + 32'd1;
      if (count == compare) timerFlag <= 1'b1;
      if (wrEn) begin
        case (waddr_i)
          REG_COUNT: begin
            count    <= wdata_i;
            countTog <= 1'b0;
          end
          REG_COMPARE: begin
            compare   <= wdata_i;
            timerFlag <= 1'b0;
          end
          REG_STATUS: begin
            statusIm  <= wdata_i[15:8];
            statusExl <= wdata_i[ST_EXL];
            statusIe  <= wdata_i[ST_IE];
          end
          REG_CAUSE: causeIpSw <= wdata_i[9:8];
          REG_EPC:   epc <= wdata_i;
          default:   ;
        endcase
      end
      if (excTake) begin
        // Nested exceptions keep the original return address
        if (!statusExl) begin
          epc     <= is_slot_i ? (pc_i - 32'd4) : pc_i;
          causeBd <= is_slot_i;
        end
        statusExl <= 1'b1;
        causeCode <= excCode;
        if (badSrc == BAD_FETCH) badVAddr <= pc_i;
        else if (badSrc == BAD_DATA) badVAddr <= bad_addr_i;
      end else if (eretTake) begin
        statusExl <= 1'b0;
      end
    end
  end

  assign flush_o  = ~rst & (excTake | eretTake);
  assign new_pc_o = rst      ? 32'd0 :
                    excTake  ? EXC_VECTOR :
                    eretTake ? epc : 32'd0;

  always_comb begin
    rdata_o = 32'd0;
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o = wdata_i;
    end else begin
      case (raddr_i)
        REG_BADVADDR: rdata_o = badVAddr;
        REG_COUNT:    rdata_o = count;
        REG_COMPARE:  rdata_o = compare;
        REG_STATUS:   rdata_o = statusVal;
        REG_CAUSE:    rdata_o = causeVal;
        REG_EPC:      rdata_o = epc;
        REG_PRID:     rdata_o = PRID_VALUE;
        default:      rdata_o = 32'd0;
      endcase
    end
  end

  assign status_o = statusVal;
  assign cause_o  = causeVal;
  assign epc_o    = epc;

endmodule

// File: tb/tb_cp0_exception.sv
// Bench for cp0_exception: directed vector table, hand-written timer/reset
// sequences and a randomized run, all checked against a behavioural model.
module tb_cp0_exception;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [5:0]  int_i;
  logic [7:0]  except_i;
  logic [31:0] pc_i;
  logic        is_slot_i;
  logic [31:0] bad_addr_i;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  cp0_exception dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .int_i(int_i), .except_i(except_i),
    .pc_i(pc_i), .is_slot_i(is_slot_i), .bad_addr_i(bad_addr_i),
    .flush_o(flush_o), .new_pc_o(new_pc_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty actual=%h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s actual=%h required=%h", name, act, e);
      end
    end
  endtask

  // behavioural model: architectural register images
  logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_cmp;
  logic [5:0]  m_intq;
  logic        m_timer, m_odd;

  // priority list below the interrupt: except_i bit and its ExcCode
  int prio_bit[7]  = '{7, 3, 6, 5, 2, 1, 0};
  int prio_code[7] = '{4, 10, 8, 9, 12, 4, 5};

  function automatic logic [31:0] m_cause_img();
    return m_cause | (32'(m_intq) << 10) | (32'(m_timer) << 15);
  endfunction

  // -2 nothing, -1 interrupt, otherwise index into the priority list
  function automatic int m_select();
    logic [31:0] c;
    c = m_cause_img();
    if (((c[15:8] & m_status[15:8]) != 8'd0) && m_status[0] && !m_status[1] && pc_i != 0)
      return -1;
    for (int i = 0; i < 7; i++)
      if (except_i[prio_bit[i]]) return i;
    return -2;
  endfunction

  function automatic logic [31:0] m_read();
    if (we_i && waddr_i == raddr_i) return wdata_i;
    case (raddr_i)
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd11: return m_cmp;
      5'd12: return m_status;
      5'd13: return m_cause_img();
      5'd14: return m_epc;
      5'd15: return 32'h0000_4220;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_bad = 0;
    m_count = 0; m_cmp = 0; m_intq = 0; m_timer = 0; m_odd = 0;
  endtask

  task automatic m_update(input int sel);
    logic [31:0] old_count, old_cmp;
    logic wr, eret;
    if (rst) begin
      m_reset();
      return;
    end
    old_count = m_count;
    old_cmp   = m_cmp;
    wr   = we_i && sel == -2;
    eret = sel == -2 && except_i[4];
    m_intq = int_i;
    if (wr && waddr_i == 5'd9) begin
      m_count = wdata_i; m_odd = 0;
    end else begin
      if (m_odd) m_count = m_count + 1;
      m_odd = !m_odd;
    end
    if (wr && waddr_i == 5'd11) begin
      m_cmp = wdata_i; m_timer = 0;
    end else if (old_count == old_cmp) m_timer = 1;
    if (wr && waddr_i == 5'd12) m_status = 32'h0040_0000 | (wdata_i & 32'h0000_FF03);
    if (wr && waddr_i == 5'd13) m_cause = (m_cause & ~32'h300) | (wdata_i & 32'h300);
    if (wr && waddr_i == 5'd14) m_epc = wdata_i;
    if (sel != -2) begin
      if (!m_status[1]) begin
        m_epc = is_slot_i ? pc_i - 4 : pc_i;
        m_cause[31] = is_slot_i;
      end
      m_status[1] = 1'b1;
      m_cause[6:2] = (sel == -1) ? 5'd0 : 5'(prio_code[sel]);
      if (sel == 0) m_bad = pc_i;
      else if (sel == 5 || sel == 6) m_bad = bad_addr_i;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  // driver
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [7:0] exc, input logic [31:0] pc,
                       input logic slot, input logic [31:0] bad, input logic [5:0] iv);
    we_i = we; waddr_i = wa; wdata_i = wd; raddr_i = ra; except_i = exc;
    pc_i = pc; is_slot_i = slot; bad_addr_i = bad; int_i = iv;
  endtask

  // one clock: model checks every cycle, optional directed constants
  task automatic cycle(input bit chk, input logic ef, input logic [31:0] epc_exp,
                       input logic [31:0] erd, input string tag);
    int sel;
    logic mf;
    logic [31:0] mpc;
    @(negedge clk);
    sel = m_select();
    mf  = !rst && (sel != -2 || except_i[4]);
    mpc = !mf ? 32'd0 : (sel != -2) ? 32'hBFC0_0380 : m_epc;
    if (chk) begin
      exp_q.push_back({31'd0, ef});   check({tag, "_flush"}, {31'd0, flush_o});
      exp_q.push_back(epc_exp);       check({tag, "_new_pc"}, new_pc_o);
      exp_q.push_back(erd);           check({tag, "_rdata"}, rdata_o);
    end
    exp_q.push_back({31'd0, mf});     check("model_flush", {31'd0, flush_o});
    exp_q.push_back(mpc);             check("model_new_pc", new_pc_o);
    exp_q.push_back(m_read());        check("model_rdata", rdata_o);
    exp_q.push_back(m_status);        check("model_status", status_o);
    exp_q.push_back(m_cause_img());   check("model_cause", cause_o);
    exp_q.push_back(m_epc);           check("model_epc", epc_o);
    m_update(sel);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra);
    drive(0, 0, 0, ra, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [7:0]  exc;
    logic [31:0] pc;
    logic        slot;
    logic [31:0] bad;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  vec_t tbl[19];

  initial begin
    tbl[0]  = '{0, 0, 0, 12, 8'h00, 0, 0, 0, 0, 0, 32'h0040_0000};
    tbl[1]  = '{1, 12, 32'h0000_FF03, 12, 8'h00, 0, 0, 0, 0, 0, 32'h0000_FF03};
    tbl[2]  = '{0, 0, 0, 12, 8'h00, 0, 0, 0, 0, 0, 32'h0040_FF03};
    tbl[3]  = '{1, 12, 32'h0000_0001, 15, 8'h00, 0, 0, 0, 0, 0, 32'h0000_4220};
    tbl[4]  = '{0, 0, 0, 14, 8'h04, 32'hBFC0_1004, 1, 0, 1, VEC, 32'h0};
    tbl[5]  = '{0, 0, 0, 14, 8'h00, 0, 0, 0, 0, 0, 32'hBFC0_1000};
    tbl[6]  = '{0, 0, 0, 13, 8'h00, 0, 0, 0, 0, 0, 32'h8000_8030};
    tbl[7]  = '{0, 0, 0, 12, 8'h00, 0, 0, 0, 0, 0, 32'h0040_0003};
    tbl[8]  = '{0, 0, 0, 12, 8'h10, 32'h100, 0, 0, 1, 32'hBFC0_1000, 32'h0040_0003};
    tbl[9]  = '{0, 0, 0, 12, 8'h00, 0, 0, 0, 0, 0, 32'h0040_0001};
    tbl[10] = '{0, 0, 0, 8, 8'h01, 32'h400, 0, 32'h8000_0002, 1, VEC, 32'h0};
    tbl[11] = '{0, 0, 0, 8, 8'h00, 0, 0, 0, 0, 0, 32'h8000_0002};
    tbl[12] = '{0, 0, 0, 13, 8'h00, 0, 0, 0, 0, 0, 32'h0000_8014};
    tbl[13] = '{0, 0, 0, 14, 8'h10, 32'h4, 0, 0, 1, 32'h400, 32'h400};
    tbl[14] = '{1, 14, 32'hDEAD_BEEF, 13, 8'h60, 32'h1234, 0, 0, 1, VEC, 32'h0000_8014};
    tbl[15] = '{0, 0, 0, 14, 8'h00, 0, 0, 0, 0, 0, 32'h0000_1234};
    tbl[16] = '{0, 0, 0, 13, 8'h00, 0, 0, 0, 0, 0, 32'h0000_8020};
    tbl[17] = '{1, 3, 32'hFFFF_FFFF, 4, 8'h00, 0, 0, 0, 0, 0, 32'h0};
    tbl[18] = '{0, 0, 0, 3, 8'h00, 0, 0, 0, 0, 0, 32'h0};

    m_reset();
    rst = 1'b1;
    idle(0);
    repeat (2) cycle(0, 0, 0, 0, "rst");
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].raddr, tbl[i].exc,
            tbl[i].pc, tbl[i].slot, tbl[i].bad, 6'd0);
      cycle(1, tbl[i].exp_flush, tbl[i].exp_pc, tbl[i].exp_rdata, $sformatf("tbl%0d", i));
    end

    // timer interrupt: Compare=10, IM7 + IE
    rst = 1'b1;
    idle(0);
    repeat (2) cycle(0, 0, 0, 0, "rst");
    rst = 1'b0;
    drive(1, 11, 32'd10, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, "tmr");
    drive(1, 12, 32'h0000_8001, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, "tmr");
    idle(0);
    repeat (18) cycle(0, 0, 0, 0, "tmr");
    idle(9);
    cycle(1, 0, 0, 32'd10, "tmr_count10");
    idle(13);
    cycle(1, 0, 0, 32'h0000_8000, "tmr_bubble");
    drive(0, 0, 0, 13, 0, 32'h80, 0, 0, 0);
    cycle(1, 1, VEC, 32'h0000_8000, "tmr_take");
    drive(1, 11, 32'h100, 13, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 32'h0000_8000, "tmr_code0");
    idle(13);
    cycle(1, 0, 0, 32'h0, "tmr_ip15_clear");

    // reset asserted while an exception is presented
    rst = 1'b1;
    drive(0, 0, 0, 12, 8'h04, 32'h44, 0, 0, 0);
    cycle(1, 0, 0, 32'h0040_8003, "rst_exc");
    rst = 1'b0;
    idle(13);
    cycle(1, 0, 0, 32'h0, "rst_cause");
    idle(12);
    cycle(1, 0, 0, 32'h0040_0000, "rst_status");

    // randomized run against the model
    for (int n = 0; n < 600; n++) begin
      logic [4:0] addrs[8];
      logic [7:0] exc;
      addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      exc = 8'd0;
      if ($urandom_range(0, 3) == 0) begin
        exc = 8'd1 << $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) exc = exc | 8'($urandom);
      end
      drive($urandom_range(0, 2) == 0, addrs[$urandom_range(0, 7)],
            ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            addrs[$urandom_range(0, 7)], exc,
            ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
            1'($urandom_range(0, 1)), $urandom,
            ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0);
      cycle(0, 0, 0, 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
